// File: rtl/block_ram_multi_word_pingpong_if.sv
// Bus bundle for the ping-pong multi-word block RAM: producer write port,
// consumer read port and the bank-ownership handshakes.
interface block_ram_multi_word_pingpong_if #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 128,
   parameter int NUM_WORDS  = 288
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0]           wr_data;
   logic [ADDR_W-1:0]               wr_addr;
   logic [NUM_WORDS-1:0]            wr_en;
   logic                            wr_done;
   logic                            wr_ready;
   logic [ADDR_W-1:0]               rd_addr;
   logic                            rd_en;
   logic                            rd_done;
   logic                            rd_ready;
   logic [DATA_WIDTH*NUM_WORDS-1:0] rd_data;
   logic                            rd_data_valid;
   logic [1:0]                      level;

   // Client side: the producer/consumer pair driving the RAM
   modport master (
      output wr_data, wr_addr, wr_en, wr_done,
      output rd_addr, rd_en, rd_done,
      input  wr_ready, rd_ready, rd_data, rd_data_valid, level
   );

   // RAM side
   modport slave (
      input  wr_data, wr_addr, wr_en, wr_done,
      input  rd_addr, rd_en, rd_done,
      output wr_ready, rd_ready, rd_data, rd_data_valid, level
   );
endinterface

// File: rtl/block_ram_multi_word_pingpong.sv
// Double-buffered multi-word block RAM. The producer fills one bank of wide
// rows (per-word write enables) while the consumer reads the other; banks
// change hands through wr_done/rd_done. Read latency is 1 or 2 cycles.
module block_ram_multi_word_pingpong #(
   parameter int    DATA_WIDTH   = 16,
   parameter int    DEPTH        = 128,
   parameter int    NUM_WORDS    = 288,
   parameter int    READ_LATENCY = 1,
   parameter string RAM_STYLE    = "auto"
) (
   input logic                            clk,
   input logic                            rst,
   block_ram_multi_word_pingpong_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int ROW_W  = DATA_WIDTH * NUM_WORDS;

   // Parameter sanity, caught at elaboration
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end
   if (RAM_STYLE != "auto" && RAM_STYLE != "block" && RAM_STYLE != "distributed" &&
       RAM_STYLE != "registers" && RAM_STYLE != "ultra") begin : g_bad_style
      $error("unsupported RAM_STYLE");
   end

   // Both banks live in one array; the bank bit is the address MSB
   (* ram_style = RAM_STYLE *) logic [ROW_W-1:0] mem [2*DEPTH];

   logic       wr_bank;
   logic       rd_bank;
   logic [1:0] full;
   logic       wr_ready;
   logic       rd_ready;
   logic       rd_acc;
   logic       wr_done_acc;
   logic       rd_done_acc;

   logic             vld_p0;
   logic [ROW_W-1:0] rd_data_p0;

   assign wr_ready    = !full[wr_bank];
   assign rd_ready    = full[rd_bank];
   assign rd_acc      = bus.rd_en && rd_ready;
   assign wr_done_acc = bus.wr_done && wr_ready;
   assign rd_done_acc = bus.rd_done && rd_ready;

   assign bus.wr_ready = wr_ready;
   assign bus.rd_ready = rd_ready;
   assign bus.level    = {1'b0, full[0]} + {1'b0, full[1]};

   // Bank ownership: wr_done hands the producer bank over, rd_done frees the
   // consumer bank. When both act they always address different banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= 2'b00;
      end else begin
         if (wr_done_acc) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
         end
         if (rd_done_acc) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   // Per-word write into the producer bank; lands before any bank toggle
   always_ff @(posedge clk) begin
      if (!rst && wr_ready) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (bus.wr_en[i]) begin
               mem[{wr_bank, bus.wr_addr}][i*DATA_WIDTH +: DATA_WIDTH] <= bus.wr_data;
            end
         end
      end
   end

   // Stage p0: capture the addressed consumer row on an accepted read
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0     <= 1'b0;
         rd_data_p0 <= '0;
      end else begin
         vld_p0 <= rd_acc;
         if (rd_acc) begin
            rd_data_p0 <= mem[{rd_bank, bus.rd_addr}];
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic             vld_p1;
      logic [ROW_W-1:0] rd_data_p1;

      // Stage p1: extra output register, data held while no read arrives
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
         end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
               rd_data_p1 <= rd_data_p0;
            end
         end
      end

      assign bus.rd_data       = rd_data_p1;
      assign bus.rd_data_valid = vld_p1;
   end else begin : g_lat1
      assign bus.rd_data       = rd_data_p0;
      assign bus.rd_data_valid = vld_p0;
   end
endmodule

// File: tb/tb_block_ram_multi_word_pingpong.sv
// Bench for the ping-pong block RAM: two instances (read latency 1 and 2)
// share one stimulus stream and are compared against a bank-queue model.
module tb_block_ram_multi_word_pingpong;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int NW = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic [1:0] wr_addr;
   logic [2:0] wr_en;
   logic       wr_done;
   logic [1:0] rd_addr;
   logic       rd_en;
   logic       rd_done;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   block_ram_multi_word_pingpong_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)) bus1 ();
   block_ram_multi_word_pingpong_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)) bus2 ();

   assign bus1.wr_data = wr_data;
   assign bus1.wr_addr = wr_addr;
   assign bus1.wr_en   = wr_en;
   assign bus1.wr_done = wr_done;
   assign bus1.rd_addr = rd_addr;
   assign bus1.rd_en   = rd_en;
   assign bus1.rd_done = rd_done;
   assign bus2.wr_data = wr_data;
   assign bus2.wr_addr = wr_addr;
   assign bus2.wr_en   = wr_en;
   assign bus2.wr_done = wr_done;
   assign bus2.rd_addr = rd_addr;
   assign bus2.rd_en   = rd_en;
   assign bus2.rd_done = rd_done;

   block_ram_multi_word_pingpong #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW), .READ_LATENCY(1), .RAM_STYLE("auto")
   ) u_lat1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );

   block_ram_multi_word_pingpong #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW), .READ_LATENCY(2), .RAM_STYLE("auto")
   ) u_lat2 (
      .clk(clk), .rst(rst), .bus(bus2.slave)
   );

   // Reference model: memory image, queue of full banks (oldest first),
   // producer bank index, and delay lines for the two read latencies.
   logic [23:0] m_mem [8];
   int          q[$];
   int          prod;
   logic        ev1, ev2, pv;
   logic [23:0] ed1, ed2, pd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] wa, input logic [2:0] we,
                       input logic [7:0] wd, input logic wdn, input logic [1:0] ra,
                       input logic re, input logic rdn);
      logic        acc;
      logic [23:0] ad;
      int          lvl;
      int          rb;
      rst = r; wr_addr = wa; wr_en = we; wr_data = wd; wr_done = wdn;
      rd_addr = ra; rd_en = re; rd_done = rdn;
      if (r) begin
         q.delete();
         prod = 0;
         ev1 = 1'b0; ed1 = '0; ev2 = 1'b0; ed2 = '0; pv = 1'b0; pd = '0;
      end else begin
         lvl = q.size();
         rb  = (lvl > 0) ? q[0] : prod;
         acc = re && (lvl > 0);
         ad  = m_mem[rb*4 + int'(ra)];
         if (lvl < 2) begin
            for (int i = 0; i < NW; i++) begin
               if (we[i]) m_mem[prod*4 + int'(wa)][i*8 +: 8] = wd;
            end
         end
         if (rdn && lvl > 0) void'(q.pop_front());
         if (wdn && lvl < 2) begin
            q.push_back(prod);
            prod = prod ^ 1;
         end
         ev2 = pv;
         if (pv) ed2 = pd;
         pv = acc;
         if (acc) pd = ad;
         ev1 = acc;
         if (acc) ed1 = ad;
      end
      @(posedge clk);
      #1;
      chk("level_l1", 32'(bus1.level), q.size());
      chk("level_l2", 32'(bus2.level), q.size());
      chk("wr_ready_l1", 32'(bus1.wr_ready), 32'(q.size() < 2));
      chk("wr_ready_l2", 32'(bus2.wr_ready), 32'(q.size() < 2));
      chk("rd_ready_l1", 32'(bus1.rd_ready), 32'(q.size() > 0));
      chk("rd_ready_l2", 32'(bus2.rd_ready), 32'(q.size() > 0));
      chk("valid_l1", 32'(bus1.rd_data_valid), 32'(ev1));
      chk("data_l1", 32'(bus1.rd_data), 32'(ed1));
      chk("valid_l2", 32'(bus2.rd_data_valid), 32'(ev2));
      chk("data_l2", 32'(bus2.rd_data), 32'(ed2));
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   typedef struct packed {
      logic        r;
      logic [1:0]  wa;
      logic [2:0]  we;
      logic [7:0]  wd;
      logic        wdn;
      logic [1:0]  ra;
      logic        re;
      logic        rdn;
      logic [1:0]  e_lvl;
      logic        e_wrdy;
      logic        e_rrdy;
      logic        e_vld;
      logic [23:0] e_data;
   } vec_t;

   function automatic vec_t v(input logic r, input logic [1:0] wa, input logic [2:0] we,
                              input logic [7:0] wd, input logic wdn, input logic [1:0] ra,
                              input logic re, input logic rdn, input logic [1:0] e_lvl,
                              input logic e_wrdy, input logic e_rrdy, input logic e_vld,
                              input logic [23:0] e_data);
      vec_t t;
      t.r = r; t.wa = wa; t.we = we; t.wd = wd; t.wdn = wdn; t.ra = ra; t.re = re;
      t.rdn = rdn; t.e_lvl = e_lvl; t.e_wrdy = e_wrdy; t.e_rrdy = e_rrdy;
      t.e_vld = e_vld; t.e_data = e_data;
      return t;
   endfunction

   vec_t tbl [20];

   initial begin
      //              r  wa  we    wd     wdn ra re rdn lvl wr rr vld data
      tbl[0]  = v(1, 0, 3'b000, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 24'h000000);
      tbl[1]  = v(0, 2, 3'b111, 8'hA5, 0, 0, 0, 0, 0, 1, 0, 0, 24'h000000);
      tbl[2]  = v(0, 0, 3'b000, 8'h00, 1, 0, 0, 0, 1, 1, 1, 0, 24'h000000);
      tbl[3]  = v(0, 0, 3'b000, 8'h00, 0, 2, 1, 0, 1, 1, 1, 1, 24'hA5A5A5);
      tbl[4]  = v(0, 0, 3'b000, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 24'hA5A5A5);
      tbl[5]  = v(0, 0, 3'b001, 8'h11, 0, 0, 0, 0, 0, 1, 0, 0, 24'hA5A5A5);
      tbl[6]  = v(0, 0, 3'b010, 8'h22, 0, 0, 0, 0, 0, 1, 0, 0, 24'hA5A5A5);
      tbl[7]  = v(0, 0, 3'b100, 8'h33, 0, 0, 0, 0, 0, 1, 0, 0, 24'hA5A5A5);
      tbl[8]  = v(0, 0, 3'b000, 8'h00, 1, 0, 0, 0, 1, 1, 1, 0, 24'hA5A5A5);
      tbl[9]  = v(0, 0, 3'b000, 8'h00, 0, 0, 1, 0, 1, 1, 1, 1, 24'h332211);
      tbl[10] = v(0, 0, 3'b000, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 24'h332211);
      tbl[11] = v(0, 1, 3'b111, 8'h01, 0, 0, 0, 0, 0, 1, 0, 0, 24'h332211);
      tbl[12] = v(0, 0, 3'b000, 8'h00, 1, 0, 0, 0, 1, 1, 1, 0, 24'h332211);
      tbl[13] = v(0, 1, 3'b111, 8'h02, 0, 0, 0, 0, 1, 1, 1, 0, 24'h332211);
      tbl[14] = v(0, 0, 3'b000, 8'h00, 1, 0, 0, 0, 2, 0, 1, 0, 24'h332211);
      tbl[15] = v(0, 1, 3'b111, 8'hFF, 0, 0, 0, 0, 2, 0, 1, 0, 24'h332211);
      tbl[16] = v(0, 0, 3'b000, 8'h00, 0, 1, 1, 0, 2, 0, 1, 1, 24'h010101);
      tbl[17] = v(0, 0, 3'b000, 8'h00, 0, 0, 0, 1, 1, 1, 1, 0, 24'h010101);
      tbl[18] = v(0, 0, 3'b000, 8'h00, 0, 1, 1, 0, 1, 1, 1, 1, 24'h020202);
      tbl[19] = v(0, 0, 3'b000, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 24'h020202);

      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      prod = 0;
      ev1 = 1'b0; ed1 = '0; ev2 = 1'b0; ed2 = '0; pv = 1'b0; pd = '0;

      // Reset, then give every row of both banks a known value
      step(1'b1, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
      for (int b = 0; b < 2; b++) begin
         for (int a = 0; a < 4; a++) begin
            step(1'b0, 2'(a), 3'b111, 8'(8'h80 + b*4 + a), 1'b0, 2'd0, 1'b0, 1'b0);
         end
         step(1'b0, 2'd0, 3'b000, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
      end
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

      // Basic write/read, partial words, ping-pong with a dropped write
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].r, tbl[i].wa, tbl[i].we, tbl[i].wd, tbl[i].wdn,
              tbl[i].ra, tbl[i].re, tbl[i].rdn);
         chk($sformatf("vec%0d_level", i), 32'(bus1.level), 32'(tbl[i].e_lvl));
         chk($sformatf("vec%0d_wr_ready", i), 32'(bus1.wr_ready), 32'(tbl[i].e_wrdy));
         chk($sformatf("vec%0d_rd_ready", i), 32'(bus1.rd_ready), 32'(tbl[i].e_rrdy));
         chk($sformatf("vec%0d_valid", i), 32'(bus1.rd_data_valid), 32'(tbl[i].e_vld));
         chk($sformatf("vec%0d_data", i), 32'(bus1.rd_data), 32'(tbl[i].e_data));
      end

      // Simultaneous wr_done and rd_done at level 1, read in the release cycle
      step(1'b0, 2'd3, 3'b111, 8'h44, 1'b0, 2'd0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
      step(1'b0, 2'd3, 3'b111, 8'h55, 1'b1, 2'd3, 1'b1, 1'b1);
      chk("simul_level", 32'(bus1.level), 32'd1);
      chk("simul_old_bank_valid", 32'(bus1.rd_data_valid), 32'd1);
      chk("simul_old_bank_data", 32'(bus1.rd_data), 32'h444444);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd3, 1'b1, 1'b0);
      chk("simul_new_bank_data", 32'(bus1.rd_data), 32'h555555);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      chk("simul_drain_level", 32'(bus1.level), 32'd0);

      // Gating: reads and done pulses while not ready
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("gate_rd_valid", 32'(bus1.rd_data_valid), 32'd0);
      chk("gate_rd_hold", 32'(bus1.rd_data), 32'h555555);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      chk("gate_rd_done_level", 32'(bus1.level), 32'd0);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
      chk("gate_wr_done_level", 32'(bus1.level), 32'd2);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd3, 1'b1, 1'b0);
      chk("gate_bank_order", 32'(bus1.rd_data), 32'h444444);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

      // Latency-2 burst, then reset in the middle of a burst
      for (int a = 0; a < 4; a++) begin
         step(1'b0, 2'(a), 3'b111, 8'(8'hC0 + a), 1'b0, 2'd0, 1'b0, 1'b0);
      end
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("lat2_first_gap", 32'(bus2.rd_data_valid), 32'd0);
      for (int a = 1; a < 5; a++) begin
         if (a < 4) step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'(a), 1'b1, 1'b0);
         else idle();
         chk($sformatf("lat2_burst%0d_valid", a - 1), 32'(bus2.rd_data_valid), 32'd1);
         chk($sformatf("lat2_burst%0d_data", a - 1), 32'(bus2.rd_data), 32'(24'hC0C0C0 + (a - 1) * 24'h010101));
      end
      idle();
      chk("lat2_after_valid", 32'(bus2.rd_data_valid), 32'd0);
      chk("lat2_after_hold", 32'(bus2.rd_data), 32'hC3C3C3);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
      step(1'b0, 2'd0, 3'b000, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0);
      step(1'b1, 2'd0, 3'b000, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0);
      chk("rst_l1_valid", 32'(bus1.rd_data_valid), 32'd0);
      chk("rst_l1_data", 32'(bus1.rd_data), 32'd0);
      chk("rst_l2_valid", 32'(bus2.rd_data_valid), 32'd0);
      chk("rst_l2_data", 32'(bus2.rd_data), 32'd0);
      chk("rst_level", 32'(bus2.level), 32'd0);
      idle();
      chk("rst_inflight_dropped", 32'(bus2.rd_data_valid), 32'd0);

      // Randomised traffic against the model
      for (int n = 0; n < 1500; n++) begin
         step(1'($urandom_range(0, 99) == 0), 2'($urandom), 3'($urandom), 8'($urandom),
              1'($urandom_range(0, 5) == 0), 2'($urandom), 1'($urandom),
              1'($urandom_range(0, 5) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
